// File: rtl/io_mmio_responder_if.sv
// CPU data-memory store/load bus seen by the MMIO responder.
// The CPU drives the address, store data and write strobe; the responder returns load data combinationally.
interface io_mmio_responder_if;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output memwrite, dataadr, writedata, input readdata);
    modport slave  (input memwrite, dataadr, writedata, output readdata);
endinterface

// File: rtl/io_mmio_responder.sv
// MMIO responder: STATUS/SWITCH/DISP/CLEAR window, debounced buttons, 8-digit seven-segment scan.
// Optional: define LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero DISP digit.
module io_mmio_responder #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0080,
    parameter int unsigned SCAN_DIV        = 100000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 reset,
    io_mmio_responder_if.slave   bus,
    input  logic                 btn_l,
    input  logic                 btn_r,
    input  logic [15:0]          sw,
    output logic [7:0]           an,
    output logic                 dp,
    output logic [6:0]           a2g
);

    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    logic [31:0]   disp;
    logic [15:0]   sw_s1, sw_s2;
    logic [1:0]    b_s1, b_s2, acc, pend, rise, clr_mask;
    logic [DW-1:0] cnt [2];
    logic [SW-1:0] scan_cnt;
    logic [2:0]    idx;
    logic [3:0]    digit;
    logic          blank;
    logic          hit, wr_disp, wr_clear;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^bus.dataadr[1:0];

    assign hit      = (bus.dataadr[31:4] == BASE_ADDR[31:4]);
    assign wr_disp  = bus.memwrite && hit && (bus.dataadr[3:2] == 2'd2);
    assign wr_clear = bus.memwrite && hit && (bus.dataadr[3:2] == 2'd3);
    assign clr_mask = wr_clear ? bus.writedata[1:0] : 2'b00;

    always_comb begin
        bus.readdata = '0;
        if (hit) begin
            case (bus.dataadr[3:2])
                2'd0:    bus.readdata = {30'b0, pend};
                2'd1:    bus.readdata = {16'b0, sw_s2};
                2'd2:    bus.readdata = disp;
                default: bus.readdata = '0;
            endcase
        end
    end

    // Bit 1 is the left button, bit 0 the right, matching the STATUS and CLEAR layouts.
    always_comb begin
        rise = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            rise[i] = b_s2[i] && !acc[i] && (cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp  <= '0;
            sw_s1 <= '0;
            sw_s2 <= '0;
            b_s1  <= '0;
            b_s2  <= '0;
            acc   <= '0;
            pend  <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            b_s1  <= {btn_l, btn_r};
            b_s2  <= b_s1;
            if (wr_disp) begin
                disp <= bus.writedata;
            end
            for (int unsigned i = 0; i < 2; i++) begin
                if (b_s2[i] != acc[i]) begin
                    if (cnt[i] == DB_LAST) begin
                        acc[i] <= b_s2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + DW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
            // A rise on the same edge as a clear keeps the flag set.
            pend <= (pend & ~clr_mask) | rise;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    assign digit = disp[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0] msd;
    always_comb begin
        msd = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (disp[4*k +: 4] != 4'h0) begin
                msd = 3'(k);
            end
        end
    end
    assign blank = (idx > msd);
`else
    assign blank = 1'b0;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        if (blank) begin
            an  = '1;
            a2g = '1;
        end else begin
            an  = ~(8'b1 << idx);
            a2g = hex7(digit);
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_io_mmio_responder.sv
// Scoreboard bench for io_mmio_responder: stimulus queues expected values, a negedge monitor compares.
// Build with +define+LEADING_ZERO_BLANK_EN to exercise digit blanking expectations.
module tb_io_mmio_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_l, btn_r;
    logic [15:0] sw;
    logic [7:0]  an;
    logic        dp;
    logic [6:0]  a2g;

    io_mmio_responder_if bus ();

    io_mmio_responder #(
        .BASE_ADDR(32'h0000_0080),
        .SCAN_DIV(4),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .btn_l(btn_l),
        .btn_r(btn_r),
        .sw(sw),
        .an(an),
        .dp(dp),
        .a2g(a2g)
    );

    always #5 clk = ~clk;

    localparam int SEL_RD  = 0;
    localparam int SEL_AN  = 1;
    localparam int SEL_A2G = 2;
    localparam int SEL_DP  = 3;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } item_t;

    item_t q[$];
    int    passed = 0;
    int    total  = 0;
    int    c      = 0;

    function automatic void push(input string name, input int sel, input logic [31:0] exp);
        item_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = exp;
        q.push_back(it);
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            item_t       it;
            logic [31:0] act;
            it = q.pop_front();
            case (it.sel)
                SEL_RD:  act = bus.readdata;
                SEL_AN:  act = {24'b0, an};
                SEL_A2G: act = {25'b0, a2g};
                default: act = {31'b0, dp};
            endcase
            total++;
            if (act === it.exp) passed++;
            else $display("FAIL %s: got %08h expected %08h (cycle %0d)", it.name, act, it.exp, c);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic wait_to(input int n);
        while (c < n) tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        c = 0;
    endtask

    task automatic seg(input string name, input logic [7:0] e_an, input logic [6:0] e_a2g);
        push({name, ".an"}, SEL_AN, {24'b0, e_an});
        push({name, ".a2g"}, SEL_A2G, {25'b0, e_a2g});
    endtask

    initial begin
        reset         = 1'b1;
        btn_l         = 1'b0;
        btn_r         = 1'b0;
        sw            = '0;
        bus.memwrite  = 1'b0;
        bus.dataadr   = '0;
        bus.writedata = '0;

        // Reset state
        do_reset(2);
        bus.dataadr = 32'h80;
        push("rst_status", SEL_RD, 32'h0);
        seg("rst", 8'hFE, 7'b1000000);
        push("rst_dp", SEL_DP, 32'h1);
        tick();
        // DISP write: same-cycle read sees old value
        bus.dataadr   = 32'h88;
        bus.memwrite  = 1'b1;
        bus.writedata = 32'h1234_5678;
        push("disp_old", SEL_RD, 32'h0);
        tick();
        bus.memwrite = 1'b0;
        push("disp_new", SEL_RD, 32'h1234_5678);
        seg("slot0", 8'hFE, 7'b0000000);
        wait_to(4);
        seg("slot1", 8'hFD, 7'b1111000);
        wait_to(8);
        seg("slot2", 8'hFB, 7'b0000010);
        push("dp_on", SEL_DP, 32'h1);
        wait_to(32);
        seg("wrap", 8'hFE, 7'b0000000);

        // Switch synchroniser and read-only write
        wait_to(33);
        sw          = 16'hBEEF;
        bus.dataadr = 32'h84;
        tick();
        push("sw_lat1", SEL_RD, 32'h0);
        tick();
        push("sw_lat2", SEL_RD, 32'h0000_BEEF);
        tick();
        bus.memwrite  = 1'b1;
        bus.writedata = 32'hFFFF_FFFF;
        push("sw_wr", SEL_RD, 32'h0000_BEEF);
        tick();
        bus.memwrite = 1'b0;
        push("sw_after", SEL_RD, 32'h0000_BEEF);
        tick();
        bus.dataadr = 32'h88;
        push("disp_kept", SEL_RD, 32'h1234_5678);
        tick();
        bus.dataadr = 32'h80;
        push("status_kept", SEL_RD, 32'h0);
        bus.dataadr = 32'h40;

        // Right button: short glitch rejected, long press sets once
        wait_to(40);
        bus.dataadr = 32'h80;
        btn_r = 1'b1;
        wait_to(42);
        btn_r = 1'b0;
        wait_to(48);
        push("glitch", SEL_RD, 32'h0);
        wait_to(50);
        btn_r = 1'b1;
        wait_to(54);
        push("r_pre", SEL_RD, 32'h0);
        wait_to(55);
        push("r_set", SEL_RD, 32'h1);
        wait_to(56);
        bus.dataadr   = 32'h8C;
        bus.memwrite  = 1'b1;
        bus.writedata = 32'h1;
        push("clear_rd0", SEL_RD, 32'h0);
        tick();
        bus.memwrite = 1'b0;
        bus.dataadr  = 32'h80;
        push("r_cleared", SEL_RD, 32'h0);
        wait_to(59);
        push("r_held", SEL_RD, 32'h0);
        wait_to(60);
        btn_r = 1'b0;

        // Left rise coincides with clear of l_pend: set wins
        wait_to(70);
        btn_l = 1'b1;
        wait_to(74);
        bus.dataadr   = 32'h8C;
        bus.memwrite  = 1'b1;
        bus.writedata = 32'h2;
        tick();
        bus.memwrite = 1'b0;
        bus.dataadr  = 32'h80;
        push("set_wins", SEL_RD, 32'h2);
        tick();
        btn_r = 1'b1;
        wait_to(82);
        push("both", SEL_RD, 32'h3);
        btn_l = 1'b0;
        btn_r = 1'b0;
        tick();

        // Reset mid-operation
        do_reset(1);
        bus.dataadr = 32'h80;
        push("rst2_status", SEL_RD, 32'h0);
        seg("rst2", 8'hFE, 7'b1000000);
        wait_to(6);
        push("rst2_later", SEL_RD, 32'h0);

        // Leading digits
        do_reset(2);
        bus.dataadr   = 32'h88;
        bus.memwrite  = 1'b1;
        bus.writedata = 32'h0000_00A5;
        tick();
        bus.memwrite = 1'b0;
        push("a5_rd", SEL_RD, 32'h0000_00A5);
        wait_to(2);
        seg("a5_d0", 8'hFE, 7'b0010010);
        wait_to(5);
        seg("a5_d1", 8'hFD, 7'b0001000);
`ifdef LEADING_ZERO_BLANK_EN
        wait_to(9);
        seg("a5_d2", 8'hFF, 7'h7F);
        wait_to(29);
        seg("a5_d7", 8'hFF, 7'h7F);
`else
        wait_to(9);
        seg("a5_d2", 8'hFB, 7'b1000000);
        wait_to(29);
        seg("a5_d7", 8'h7F, 7'b1000000);
`endif
        wait_to(30);
        bus.memwrite  = 1'b1;
        bus.writedata = 32'h0;
        tick();
        bus.memwrite = 1'b0;
        push("zero_rd", SEL_RD, 32'h0);
        wait_to(33);
        seg("zero_d0", 8'hFE, 7'b1000000);
        wait_to(37);
`ifdef LEADING_ZERO_BLANK_EN
        seg("zero_d1", 8'hFF, 7'h7F);
`else
        seg("zero_d1", 8'hFD, 7'b1000000);
`endif
        tick();
        tick();
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/io_mmio_responder.md
Name: io_mmio_responder

Overview:
Memory-mapped I/O responder at the data-memory side of the single-cycle CPU's store/load interface (dataadr, writedata, memwrite).
- Decodes a small register window.
- Returns read data combinationally, as the single-cycle datapath requires.
- Debounces the L/R push-buttons into sticky event flags.
- Drives the 8-digit multiplexed seven-segment display (an, a2g, dp) from a CPU-written 32-bit register.

Parameters:
BASE_ADDR, 32'h0000_0080, byte address of register window (16-byte aligned)
SCAN_DIV, 100000, clk cycles each digit is lit (>=2)
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples needed to accept a new button level (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
memwrite  in  1  CPU store strobe, sampled on rising clk edge
dataadr  in  32  CPU byte address
writedata  in  32  CPU store data
readdata  out  32  load data, combinational from dataadr
btn_l  in  1  left button, asynchronous, active-high
btn_r  in  1  right button, asynchronous, active-high
sw  in  16  slide switches, asynchronous
an  out  8  digit enables, active-low
dp  out  1  decimal point, active-low
a2g  out  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, reset). All state below is cleared only on a rising clk edge with reset=1.
- Decode: hit when dataadr[31:4]==BASE_ADDR[31:4]. Register selected by dataadr[3:2]. dataadr[1:0] ignored (word access only).
- Register map (offset from BASE_ADDR):
  - 0x0 STATUS (RO): {30'b0, l_pend, r_pend}.
  - 0x4 SWITCH (RO): {16'b0, sw_sync}. sw passes through a 2-flop synchroniser, so latency is 2 cycles.
  - 0x8 DISP (RW): 32-bit value shown as 8 hex digits; digit k = DISP[4k+3:4k]; digit 0 on an[0].
  - 0xC CLEAR (WO, reads 0): write-1-to-clear; writedata[0] clears r_pend, writedata[1] clears l_pend.
- Reads: readdata updates combinationally with dataadr, independent of memwrite. A miss returns 32'h0. A same-cycle DISP write reads back the old value; the new value is visible the next cycle.
- Writes: take effect at the clk edge when memwrite=1 and the address hits a writable register. Writes to STATUS, SWITCH or a miss are ignored.
- Button path (per button):
  - 2-flop synchroniser, then a debounce counter.
  - When the sync level differs from the accepted level, the counter increments. When it reaches DEBOUNCE_CYCLES, the accepted level updates and the counter clears.
  - If the sync level returns to the accepted level before that, the counter clears.
  - A 0->1 transition of the accepted level sets the pend flag.
  - If set and CLEAR happen on the same edge, set wins, so no event is lost.
  - A held button sets the flag once only.
- Display scan:
  - scan_cnt counts 0..SCAN_DIV-1. On wrap, digit index idx increments mod 8 (7 wraps to 0).
  - an = ~(8'b1 << idx).
  - a2g = active-low hex decode of digit idx, standard A-F glyphs (0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110).
  - dp = 1 (off) always.
- Reset values:
  - DISP = 0; l_pend = r_pend = 0; accepted levels = 0; debounce and scan counters = 0; idx = 0.
  - Hence an = 8'hFE, a2g = 7'b1000000, dp = 1 in the first cycle after reset.
  - readdata is combinational and has no reset value.
- Reset mid-operation: a debounce in progress is discarded, pending flags are lost, and the scan restarts at digit 0.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digits above the most significant nonzero digit of DISP are blanked (an bit held 1 and a2g = 7'h7F during their slot). Digit 0 is always shown, so DISP=0 displays a single "0". Scan timing is unchanged.
- Undefined: all 8 digits are always lit, including leading zeros.

Test Plan:
Bench parameters: BASE_ADDR=32'h80, SCAN_DIV=4, DEBOUNCE_CYCLES=3.
1. Reset held 2 cycles, then released -> an=8'hFE, a2g=7'b1000000, dp=1; dataadr=0x80 gives readdata=0; dataadr=0x88 gives readdata=0.
2. Store 32'h1234_5678 to 0x88 -> readdata at 0x88 = 32'h12345678 from the next cycle. During the an=8'hFE slot a2g = glyph "8" (7'b0000000); after 4 cycles an=8'hFD with glyph "7" (7'b1111000); after 32 cycles back to an=8'hFE.
3. sw=16'hBEEF, dataadr=0x84 -> readdata=32'h0000BEEF within 2 cycles. Store 32'hFFFF_FFFF to 0x84 -> no state change.
4. btn_r high for 2 cycles, then low -> r_pend stays 0. btn_r held high for 10 cycles -> readdata at 0x80 = 32'h1 exactly once set. Store 32'h1 to 0x8C -> reads 32'h0 next cycle while the button is still held.
5. Clear of l_pend (store 32'h2 to 0x8C) on the same edge as a debounced btn_l rise -> STATUS = 32'h2 afterwards. Assert reset with both flags set -> STATUS = 0 and an=8'hFE.
6. With LEADING_ZERO_BLANK_EN and DISP=32'h0000_00A5 -> a2g=7'h7F and an=8'hFF during slots 2-7; digits 0/1 show "5"/"A". With DISP=0 -> only digit 0 lit, showing "0".
